param_reservation_station: RTL and testbench

Next-generation ALU/branch reservation station for the Tomasulo core, with arbitrary depth and ROB width. It accepts one dispatched instruction per cycle and snoops the CDB for operands. It issues the oldest ready entry (by ROB age relative to the ROB head) to an embedded ALU. The result is held in an output register until the CDB arbiter grants it. It fixes signed/unsigned compare semantics and masks shift amounts.

---
 rtl/param_reservation_station.sv | 195 +++++++++++++++++++
 tb/tb_param_reservation_station.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_reservation_station.sv
// param_reservation_station: oldest-first ALU/branch reservation station with CDB snoop and a held result register.
// Optional macro RS_DISPATCH_BYPASS_EN: dispatched operands capture a same-cycle CDB broadcast.
module param_reservation_station #(
    parameter int RS_DEPTH = 8,
    parameter int ROB_WIDTH = 3,
    parameter logic [ROB_WIDTH:0] NON_DEP = {1'b1, {ROB_WIDTH{1'b0}}}
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_in,
    input  logic [ROB_WIDTH-1:0]         rob_head,
    input  logic                         disp_valid,
    input  logic [ROB_WIDTH-1:0]         disp_rob,
    input  logic [6:0]                   disp_op,
    input  logic [31:0]                  disp_vj,
    input  logic [31:0]                  disp_vk,
    input  logic [ROB_WIDTH:0]           disp_qj,
    input  logic [ROB_WIDTH:0]           disp_qk,
    input  logic [31:0]                  disp_imm,
    input  logic [31:0]                  disp_pc,
    input  logic                         cdb_valid,
    input  logic [ROB_WIDTH-1:0]         cdb_rob,
    input  logic [31:0]                  cdb_data,
    output logic                         res_valid,
    output logic [ROB_WIDTH-1:0]         res_rob,
    output logic [31:0]                  res_data,
    input  logic                         res_grant,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(RS_DEPTH+1)-1:0] count
);
    localparam int IW = $clog2(RS_DEPTH);
    localparam int CW = $clog2(RS_DEPTH+1);

    logic [RS_DEPTH-1:0]  busy;
    logic [ROB_WIDTH-1:0] rob [RS_DEPTH];
    logic [6:0]           op  [RS_DEPTH];
    logic [31:0]          vj  [RS_DEPTH];
    logic [31:0]          vk  [RS_DEPTH];
    logic [ROB_WIDTH:0]   qj  [RS_DEPTH];
    logic [ROB_WIDTH:0]   qk  [RS_DEPTH];
    logic [31:0]          imm [RS_DEPTH];
    logic [31:0]          pc  [RS_DEPTH];

    logic                 has_free, any_ready, do_issue;
    logic [IW-1:0]        free_idx, sel_idx;
    logic [ROB_WIDTH-1:0] age, best_age;
    logic [CW-1:0]        cnt;
    logic                 byp_j, byp_k;
    logic [ROB_WIDTH:0]   new_qj, new_qk;
    logic [31:0]          new_vj, new_vk;
    logic [6:0]           op_s;
    logic [31:0]          a, b, imm_s, pc_s, alu;
    logic [4:0]           shamt;
    logic                 taken;

    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        cnt = '0;
        for (int i = RS_DEPTH-1; i >= 0; i--) begin
            if (!busy[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
            cnt = cnt + CW'(busy[i]);
        end
    end

    assign full  = !has_free;
    assign empty = cnt == '0;
    assign count = cnt;

    // Age is the distance from the ROB head, so the smallest age is the oldest instruction.
    always_comb begin
        any_ready = 1'b0;
        sel_idx = '0;
        best_age = '1;
        age = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            age = rob[i] - rob_head;
            if (busy[i] && qj[i] == NON_DEP && qk[i] == NON_DEP && (!any_ready || age < best_age)) begin
                any_ready = 1'b1;
                sel_idx = IW'(i);
                best_age = age;
            end
        end
    end

    assign do_issue = any_ready && (!res_valid || res_grant);

`ifdef RS_DISPATCH_BYPASS_EN
    assign byp_j = cdb_valid && disp_qj == {1'b0, cdb_rob};
    assign byp_k = cdb_valid && disp_qk == {1'b0, cdb_rob};
`else
    assign byp_j = 1'b0;
    assign byp_k = 1'b0;
`endif

    assign new_qj = byp_j ? NON_DEP : disp_qj;
    assign new_qk = byp_k ? NON_DEP : disp_qk;
    assign new_vj = byp_j ? cdb_data : disp_vj;
    assign new_vk = byp_k ? cdb_data : disp_vk;

    assign op_s  = op[sel_idx];
    assign a     = vj[sel_idx];
    assign imm_s = imm[sel_idx];
    assign pc_s  = pc[sel_idx];
    assign b     = (op_s >= 7'd19 && op_s <= 7'd27) ? imm_s : vk[sel_idx];
    assign shamt = b[4:0];

    always_comb begin
        taken = op_s == 7'd5  ? a == b :
                op_s == 7'd6  ? a != b :
                op_s == 7'd7  ? $signed(a) <  $signed(b) :
                op_s == 7'd8  ? $signed(a) >= $signed(b) :
                op_s == 7'd9  ? a <  b :
                op_s == 7'd10 ? a >= b : 1'b0;
        case (op_s)
            7'd4:                            alu = (a + imm_s) & ~32'd1;
            7'd5, 7'd6, 7'd7, 7'd8, 7'd9, 7'd10: alu = taken ? pc_s + imm_s : pc_s + 32'd4;
            7'd19, 7'd28:                    alu = a + b;
            7'd29:                           alu = a - b;
            7'd20, 7'd31:                    alu = {31'd0, $signed(a) < $signed(b)};
            7'd21, 7'd32:                    alu = {31'd0, a < b};
            7'd22, 7'd33:                    alu = a ^ b;
            7'd23, 7'd36:                    alu = a | b;
            7'd24, 7'd37:                    alu = a & b;
            7'd25, 7'd30:                    alu = a << shamt;
            7'd26, 7'd34:                    alu = a >> shamt;
            7'd27, 7'd35:                    alu = $signed(a) >>> shamt;
            default:                         alu = 32'd0;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy <= '0;
            res_valid <= 1'b0;
            res_rob <= '0;
            res_data <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                rob[i] <= '0;
                op[i] <= '0;
                vj[i] <= '0;
                vk[i] <= '0;
                qj[i] <= NON_DEP;
                qk[i] <= NON_DEP;
                imm[i] <= '0;
                pc[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                busy <= '0;
                res_valid <= 1'b0;
                for (int i = 0; i < RS_DEPTH; i++) begin
                    qj[i] <= NON_DEP;
                    qk[i] <= NON_DEP;
                end
            end else begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (busy[i] && cdb_valid && qj[i] == {1'b0, cdb_rob}) begin
                        qj[i] <= NON_DEP;
                        vj[i] <= cdb_data;
                    end
                    if (busy[i] && cdb_valid && qk[i] == {1'b0, cdb_rob}) begin
                        qk[i] <= NON_DEP;
                        vk[i] <= cdb_data;
                    end
                end
                if (do_issue) begin
                    busy[sel_idx] <= 1'b0;
                    res_valid <= 1'b1;
                    res_rob <= rob[sel_idx];
                    res_data <= alu;
                end else if (res_grant) begin
                    res_valid <= 1'b0;
                end
                // The free slot is never the issuing one, so both can happen on one edge.
                if (disp_valid && has_free) begin
                    busy[free_idx] <= 1'b1;
                    rob[free_idx] <= disp_rob;
                    op[free_idx] <= disp_op;
                    vj[free_idx] <= new_vj;
                    vk[free_idx] <= new_vk;
                    qj[free_idx] <= new_qj;
                    qk[free_idx] <= new_qk;
                    imm[free_idx] <= disp_imm;
                    pc[free_idx] <= disp_pc;
                end
            end
        end
    end
endmodule

// File: tb/tb_param_reservation_station.sv
// tb_param_reservation_station: directed scoreboard bench for param_reservation_station.
module tb_param_reservation_station;
    localparam logic [3:0] ND = 4'b1000;

    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush_in = 1'b0;
    logic [2:0]  rob_head = '0;
    logic        disp_valid = 1'b0;
    logic [2:0]  disp_rob = '0;
    logic [6:0]  disp_op = '0;
    logic [31:0] disp_vj = '0, disp_vk = '0, disp_imm = '0, disp_pc = '0;
    logic [3:0]  disp_qj = ND, disp_qk = ND;
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_rob = '0;
    logic [31:0] cdb_data = '0;
    logic        res_valid, res_grant = 1'b0, full, empty;
    logic [2:0]  res_rob;
    logic [31:0] res_data;
    logic [3:0]  count;

    int vectors = 0, errors = 0;
    logic [34:0] sb [$];

    param_reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .rob_head(rob_head), .disp_valid(disp_valid), .disp_rob(disp_rob), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_imm(disp_imm), .disp_pc(disp_pc), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
        .cdb_data(cdb_data), .res_valid(res_valid), .res_rob(res_rob), .res_data(res_data),
        .res_grant(res_grant), .full(full), .empty(empty), .count(count)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic dispatch(input logic [2:0] r, input logic [6:0] o, input logic [31:0] vj,
                            input logic [31:0] vk, input logic [3:0] qj, input logic [3:0] qk,
                            input logic [31:0] im, input logic [31:0] p);
        disp_rob = r; disp_op = o; disp_vj = vj; disp_vk = vk;
        disp_qj = qj; disp_qk = qk; disp_imm = im; disp_pc = p;
        disp_valid = 1'b1;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic run(input logic [2:0] r, input logic [6:0] o, input logic [31:0] vj,
                       input logic [31:0] vk, input logic [31:0] im, input logic [31:0] p,
                       input logic [31:0] exp);
        sb.push_back({r, exp});
        dispatch(r, o, vj, vk, ND, ND, im, p);
    endtask

    task automatic broadcast(input logic [2:0] r, input logic [31:0] d);
        cdb_valid = 1'b1; cdb_rob = r; cdb_data = d;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic drain();
        logic [34:0] e;
        int n;
        while (sb.size() > 0) begin
            n = 0;
            while (res_valid !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            e = sb.pop_front();
            chk("res_valid", 32'(res_valid), 32'd1);
            chk("res_rob", 32'(res_rob), 32'(e[34:32]));
            chk("res_data", res_data, e[31:0]);
            res_grant = 1'b1;
            tick();
            res_grant = 1'b0;
        end
    endtask

    initial begin
        #2;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_rob", 32'(res_rob), 32'd0);
        tick();
        rst_in = 1'b0;
        tick();

        // backpressure: add 5+3 held while ungranted, sub queued behind it
        run(3'd0, 7'd28, 32'd5, 32'd3, 32'd0, 32'd0, 32'd8);
        chk("lat_not_yet", 32'(res_valid), 32'd0);
        chk("lat_count", 32'(count), 32'd1);
        tick();
        chk("lat_valid", 32'(res_valid), 32'd1);
        run(3'd1, 7'd29, 32'd10, 32'd4, 32'd0, 32'd0, 32'd6);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_data", res_data, 32'd8);
            chk("bp_count", 32'(count), 32'd1);
            tick();
        end
        drain();
        chk("bp_idle", 32'(res_valid), 32'd0);

        // oldest-first across ROB wrap
        rob_head = 3'd6;
        dispatch(3'd1, 7'd19, 32'd0, 32'd0, 4'd5, ND, 32'd1, 32'd0);
        dispatch(3'd7, 7'd22, 32'd0, 32'd0, 4'd5, ND, 32'hF, 32'd0);
        sb.push_back({3'd7, 32'h1F});
        sb.push_back({3'd1, 32'h11});
        broadcast(3'd5, 32'h10);
        chk("capture_not_same_cycle", 32'(res_valid), 32'd0);
        drain();
        rob_head = 3'd0;

        // arithmetic group A
        run(3'd0, 7'd7,  32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 32'h120);
        run(3'd1, 7'd9,  32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 32'h104);
        run(3'd2, 7'd35, 32'h80000000, 32'd33, 32'd0, 32'd0, 32'hC0000000);
        run(3'd3, 7'd31, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd1);
        run(3'd4, 7'd32, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0);
        run(3'd5, 7'd4,  32'h1001, 32'd0, 32'd4, 32'd0, 32'h1004);
        run(3'd6, 7'd27, 32'h80000000, 32'd0, 32'h24, 32'd0, 32'hF8000000);
        run(3'd7, 7'd29, 32'd0, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFF);
        drain();

        // arithmetic group B
        run(3'd0, 7'd8,  32'hFFFFFFFF, 32'd1, 32'h40, 32'h200, 32'h204);
        run(3'd1, 7'd5,  32'd7, 32'd7, 32'hFFFFFFF0, 32'h300, 32'h2F0);
        run(3'd2, 7'd50, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0);
        run(3'd3, 7'd37, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 32'h00F0);
        run(3'd4, 7'd30, 32'd1, 32'd36, 32'd0, 32'd0, 32'h10);
        run(3'd5, 7'd34, 32'h80000000, 32'd31, 32'd0, 32'd0, 32'd1);
        run(3'd6, 7'd28, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'd1);
        run(3'd7, 7'd21, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd1);
        drain();

        // full, dropped dispatch, flush
        for (int i = 0; i < 8; i++) dispatch(3'(i), 7'd28, 32'd0, 32'd1, 4'd2, ND, 32'd0, 32'd0);
        chk("full", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd8);
        chk("full_empty", 32'(empty), 32'd0);
        dispatch(3'd0, 7'd28, 32'd1, 32'd1, ND, ND, 32'd0, 32'd0);
        chk("drop_count", 32'(count), 32'd8);
        tick();
        chk("drop_no_issue", 32'(res_valid), 32'd0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_full", 32'(full), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        broadcast(3'd2, 32'd9);
        tick();
        chk("flush_gone", 32'(res_valid), 32'd0);
        flush_in = 1'b1;
        dispatch(3'd3, 7'd28, 32'd1, 32'd1, ND, ND, 32'd0, 32'd0);
        flush_in = 1'b0;
        chk("flush_disp_count", 32'(count), 32'd0);
        tick();
        chk("flush_disp_valid", 32'(res_valid), 32'd0);
        dispatch(3'd3, 7'd28, 32'd1, 32'd1, ND, ND, 32'd0, 32'd0);
        tick();
        chk("pre_flush_valid", 32'(res_valid), 32'd1);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("flush_res_valid", 32'(res_valid), 32'd0);

        // rdy_in low freezes
        rdy_in = 1'b0;
        dispatch(3'd2, 7'd28, 32'd1, 32'd1, ND, ND, 32'd0, 32'd0);
        tick();
        chk("frozen_count", 32'(count), 32'd0);
        chk("frozen_valid", 32'(res_valid), 32'd0);
        rdy_in = 1'b1;

        // same-cycle dispatch/CDB tag hit
        cdb_valid = 1'b1; cdb_rob = 3'd3; cdb_data = 32'h55;
        dispatch(3'd1, 7'd28, 32'h999, 32'd1, 4'd3, ND, 32'd0, 32'd0);
        cdb_valid = 1'b0;
        sb.push_back({3'd1, 32'h56});
        tick();
`ifdef RS_DISPATCH_BYPASS_EN
        chk("bypass_issue", 32'(res_valid), 32'd1);
`else
        chk("no_bypass_wait", 32'(res_valid), 32'd0);
        broadcast(3'd3, 32'h55);
`endif
        drain();

        // asynchronous reset with busy entries and a pending result
        dispatch(3'd4, 7'd28, 32'd2, 32'd2, ND, ND, 32'd0, 32'd0);
        for (int i = 1; i < 4; i++) dispatch(3'(i), 7'd28, 32'd0, 32'd1, 4'd2, ND, 32'd0, 32'd0);
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_valid", 32'(res_valid), 32'd1);
        #2 rst_in = 1'b1;
        #1;
        chk("async_rst_valid", 32'(res_valid), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_count", 32'(count), 32'd0);
        #2 rst_in = 1'b0;
        tick();
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
